// File: rtl/lut_interp_sched.sv
// rtl/lut_interp_sched.sv - round-robin scheduler sharing one interpolating activation LUT
module lut_interp_sched #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic [3:0]         lut_address,
    input  logic [7:0]         lut_base,
    input  logic [7:0]         lut_next,
    output logic               rsp_valid,
    output logic [ID_W-1:0]    rsp_id,
    output logic [7:0]         rsp_data,
    input  logic               rsp_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_CALC,
        S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [3:0]       frac_q, frac_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [3:0]       addr_q, addr_d;
    logic [7:0]       base_q, base_d;
    logic [7:0]       next_q, next_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [7:0]       rsp_data_q, rsp_data_d;

    logic [N_REQ-1:0] req_rot;
    logic             win_found;
    logic [ID_W:0]    win_sum;
    logic [ID_W-1:0]  win_id;
    logic [7:0]       x_sel;
    logic             grant;

    logic signed [8:0]  diff;
    logic signed [13:0] prod;
    logic signed [13:0] delta;
    logic signed [13:0] sum;
    logic [7:0]         sat;

    // Rotate so that bit 0 is the requester at rr_ptr; the first set bit wins.
    assign req_rot = N_REQ'({req_valid, req_valid} >> rr_ptr_q);

    always_comb begin
        win_found = 1'b0;
        win_sum   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!win_found && req_rot[k]) begin
                win_found = 1'b1;
                win_sum   = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            end
        end
        if (win_sum >= (ID_W+1)'(N_REQ)) begin
            win_sum = win_sum - (ID_W+1)'(N_REQ);
        end
        win_id = win_sum[ID_W-1:0];
    end

    always_comb begin
        x_sel = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (win_id == ID_W'(k)) begin
                x_sel = req_data[8*k +: 8];
            end
        end
    end

    // Grant is masked by reset so req_ready drops the instant reset asserts.
    assign grant     = rst && (state_q == S_IDLE) && win_found;
    assign req_ready = grant ? (N_REQ'(1) << win_id) : '0;

    always_comb begin
        diff  = $signed({next_q[7], next_q}) - $signed({base_q[7], base_q});
        prod  = $signed({{5{diff[8]}}, diff}) * $signed({10'b0, frac_q});
        delta = prod >>> 4;
        sum   = $signed({{6{base_q[7]}}, base_q}) + delta;
        if (sum > 14'sd127) begin
            sat = 8'h7f;
        end else if (sum < -14'sd128) begin
            sat = 8'h80;
        end else begin
            sat = sum[7:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        frac_d      = frac_q;
        id_d        = id_q;
        addr_d      = addr_q;
        base_d      = base_q;
        next_d      = next_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    frac_d   = x_sel[3:0];
                    addr_d   = x_sel[7:4];
                    id_d     = win_id;
                    rr_ptr_d = (win_id == ID_W'(N_REQ-1)) ? '0 : win_id + 1'b1;
                    state_d  = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                base_d  = lut_base;
                next_d  = lut_next;
                state_d = S_CALC;
            end
            S_CALC: begin
                rsp_data_d  = sat;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            frac_q      <= '0;
            id_q        <= '0;
            addr_q      <= '0;
            base_q      <= '0;
            next_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            frac_q      <= frac_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            base_q      <= base_d;
            next_q      <= next_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign lut_address = addr_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_data    = rsp_data_q;

endmodule

// File: tb/tb_lut_interp_sched.sv
// tb/tb_lut_interp_sched.sv - self-checking bench for lut_interp_sched
module tb_lut_interp_sched;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [3:0]     lut_address;
    logic [7:0]     lut_base;
    logic [7:0]     lut_next;
    logic           rsp_valid;
    logic [1:0]     rsp_id;
    logic [7:0]     rsp_data;
    logic           rsp_ready;

    logic [7:0]     lut_mem [16];
    int             n_vec;
    int             n_err;
    int             acc_ids[$];

    typedef struct {
        int id;
        int x;
        int exp_data;
        int exp_addr;
    } vec_t;

    vec_t vecs[8];
    int   want_order[6];

    always #5 clk = ~clk;

    lut_interp_sched #(.N_REQ(N), .ID_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .lut_address(lut_address),
        .lut_base   (lut_base),
        .lut_next   (lut_next),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_ready  (rsp_ready)
    );

    function automatic int next_entry(input int a);
        if (a == 15) return 0;
        if (a == 7) return 7;
        return a + 1;
    endfunction

    always_comb begin
        lut_base = lut_mem[lut_address];
        lut_next = lut_mem[4'(next_entry(int'(lut_address)))];
    end

    function automatic int sval(input int a);
        return int'($signed(lut_mem[a]));
    endfunction

    // Reference: linear interpolation with floor division, then clamp.
    function automatic int ref_interp(input int x);
        int a, f, b, n, p, d, s;
        a = x / 16;
        f = x % 16;
        b = sval(a);
        n = sval(next_entry(a));
        p = (n - b) * f;
        d = (p >= 0) ? p / 16 : -((-p + 15) / 16);
        s = b + d;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req_valid = '0;
        req_data = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset req_ready", int'(req_ready), 0);
        chk("reset lut_address", int'(lut_address), 0);
        chk("reset rsp_valid", int'(rsp_valid), 0);
        chk("reset rsp_id", int'(rsp_id), 0);
        chk("reset rsp_data", int'(rsp_data), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic single_txn(input int id, input int x, input int exp_data,
                              input int exp_addr, input string tag);
        int lat;
        bit got;
        req_data[8*id +: 8] = 8'(x);
        req_valid = 4'(1 << id);
        rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (req_ready[id]) got = 1;
        end
        chk({tag, " grant"}, got ? int'(req_ready) : -1, 1 << id);
        if (!got) begin
            req_valid = '0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        chk({tag, " lut_address"}, int'(lut_address), exp_addr);
        lat = 0;
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) got = 1;
        end
        chk({tag, " latency"}, got ? lat : -1, 3);
        chk({tag, " rsp_id"}, int'(rsp_id), id);
        chk({tag, " rsp_data"}, int'($signed(rsp_data)), exp_data);
        @(posedge clk);
        #1;
        chk({tag, " rsp_valid cleared"}, int'(rsp_valid), 0);
    endtask

    // Cycle-level scoreboard: round-robin winner, busy window, fixed latency, in-order results.
    task automatic run_stream(input int cycles, input bit rand_mode);
        int ptr, cnt, w, exp_addr;
        bit busy, accepted, handshake;
        int exp_id_q[$];
        int exp_dat_q[$];
        ptr = 0;
        cnt = 0;
        busy = 0;
        exp_addr = 0;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            @(negedge clk);
            accepted = 0;
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && req_valid[(ptr + k) % N]) w = (ptr + k) % N;
            end
            if (busy) begin
                chk("busy no grant", int'(req_ready), 0);
                chk("rsp_valid timing", int'(rsp_valid), (cnt >= 3) ? 1 : 0);
                if (rsp_valid && exp_id_q.size() > 0) begin
                    chk("stream rsp_id", int'(rsp_id), exp_id_q[0]);
                    chk("stream rsp_data", int'($signed(rsp_data)), exp_dat_q[0]);
                end
            end else begin
                chk("rr grant", int'(req_ready), (w >= 0) ? (1 << w) : 0);
                if (w >= 0) begin
                    accepted = 1;
                    acc_ids.push_back(w);
                    exp_id_q.push_back(w);
                    exp_dat_q.push_back(ref_interp(int'(req_data[8*w +: 8])));
                    exp_addr = int'(req_data[8*w +: 8]) / 16;
                    ptr = (w + 1) % N;
                end
            end
            handshake = busy && rsp_valid && rsp_ready;
            @(posedge clk);
            #1;
            if (accepted) begin
                busy = 1;
                cnt = 1;
                chk("stream lut_address", int'(lut_address), exp_addr);
                req_data[8*w +: 8] = 8'($urandom);
                if (rand_mode) req_valid[w] = 1'($urandom_range(0, 1));
            end else if (busy) begin
                cnt++;
            end
            if (handshake) begin
                busy = 0;
                void'(exp_id_q.pop_front());
                void'(exp_dat_q.pop_front());
            end
            if (rand_mode) begin
                rsp_ready = ($urandom_range(0, 3) != 0);
                for (int i = 0; i < N; i++) begin
                    if (!(accepted && i == w)) begin
                        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                            req_valid[i] = 1'b1;
                            req_data[8*i +: 8] = 8'($urandom);
                        end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
                            req_valid[i] = 1'b0;
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        bit got;
        n_vec = 0;
        n_err = 0;
        for (int a = 0; a < 16; a++) lut_mem[a] = 8'(16 * a);
        vecs[0] = '{1, 'h25, 37, 2};
        vecs[1] = '{0, 'hFF, -1, 15};
        vecs[2] = '{0, 'h80, -128, 8};
        vecs[3] = '{2, 'h7F, 112, 7};
        vecs[4] = '{3, 'h00, 0, 0};
        vecs[5] = '{3, 'h6F, 111, 6};
        vecs[6] = '{1, 'hF0, -16, 15};
        vecs[7] = '{2, 'h88, -120, 8};
        want_order = '{0, 1, 2, 3, 0, 1};

        do_reset();
        for (int v = 0; v < 8; v++) begin
            single_txn(vecs[v].id, vecs[v].x, vecs[v].exp_data, vecs[v].exp_addr,
                       $sformatf("vec%0d", v));
        end

        // All requesters valid from reset: strict rotation.
        do_reset();
        acc_ids.delete();
        for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'($urandom);
        req_valid = '1;
        rsp_ready = 1'b1;
        run_stream(40, 0);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("fair order %0d", i), (acc_ids.size() > i) ? acc_ids[i] : -1,
                want_order[i]);
        end

        // Backpressure: response held, no grants, then the waiting requester wins.
        do_reset();
        req_data[15:8] = 8'h25;
        req_data[23:16] = 8'h33;
        req_valid = 4'b0110;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp first grant", int'(req_ready), 2);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (rsp_valid) got = 1;
        end
        chk("bp rsp_valid seen", int'(got), 1);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            chk("bp rsp_valid held", int'(rsp_valid), 1);
            chk("bp rsp_id held", int'(rsp_id), 1);
            chk("bp rsp_data held", int'($signed(rsp_data)), 37);
            chk("bp no grant", int'(req_ready), 0);
            chk("bp lut_address held", int'(lut_address), 2);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp handshake cycle valid", int'(rsp_valid), 1);
        chk("bp handshake cycle no grant", int'(req_ready), 0);
        @(negedge clk);
        chk("bp after handshake valid", int'(rsp_valid), 0);
        chk("bp next grant", int'(req_ready), 4);
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (6) @(posedge clk);

        // Asynchronous reset while in CALC.
        do_reset();
        req_data[23:16] = 8'h25;
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rst grant", int'(req_ready), 4);
        @(posedge clk);
        #1;
        req_valid = 4'b1111;
        @(posedge clk);
        #2;
        chk("rst pre lut_address", int'(lut_address), 2);
        rst = 1'b0;
        #1;
        chk("rst async rsp_valid", int'(rsp_valid), 0);
        chk("rst async req_ready", int'(req_ready), 0);
        chk("rst async lut_address", int'(lut_address), 0);
        chk("rst async rsp_data", int'(rsp_data), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
        got = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid) got = 1;
        end
        chk("rst no stale response", int'(got), 0);
        @(posedge clk);
        #1;
        req_valid = 4'b1111;
        @(negedge clk);
        chk("rst first grant", int'(req_ready), 1);
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (6) @(posedge clk);

        // Random traffic against a random LUT.
        for (int a = 0; a < 16; a++) lut_mem[a] = 8'($urandom);
        do_reset();
        for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'($urandom);
        req_valid = 4'($urandom);
        rsp_ready = 1'b1;
        run_stream(3000, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
